// File: rtl/bus_target_pkg.sv
// Shared definitions for the bus target: console MUX register map, STATUS
// bit layout and the value returned for unmapped reads.
package bus_target_pkg;

  localparam logic [15:0] MUX_STATUS_OFS = 16'd0;
  localparam logic [15:0] MUX_DATA_OFS   = 16'd1;

  localparam int unsigned ST_RX_FULL     = 0;
  localparam int unsigned ST_TX_NOT_FULL = 1;
  localparam int unsigned ST_RX_OVERRUN  = 2;
  localparam int unsigned ST_TX_OVERFLOW = 3;

  localparam logic [7:0] UNMAPPED_READ = 8'hFF;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_STATUS,
    REGION_DATA
  } region_t;

  function automatic logic [7:0] pack_status(input logic rx_full,
                                             input logic tx_not_full,
                                             input logic rx_overrun,
                                             input logic tx_overflow);
    logic [7:0] s;
    s                 = '0;
    s[ST_RX_FULL]     = rx_full;
    s[ST_TX_NOT_FULL] = tx_not_full;
    s[ST_RX_OVERRUN]  = rx_overrun;
    s[ST_TX_OVERFLOW] = tx_overflow;
    return s;
  endfunction

endpackage

// File: rtl/bus_target_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; simultaneous push and pop are
// both honoured even when full.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop & ~empty;
    // a full FIFO still accepts a push when a pop frees the slot this cycle
    do_push  = push & (~full | do_pop);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_target.sv
// CPU bus target: byte RAM at the bottom of the map plus a console MUX
// (STATUS / DATA) with an rx holding register and a TX FIFO.
module bus_target
  import bus_target_pkg::*;
#(
  parameter int unsigned RAM_AW    = 15,
  parameter logic [15:0] MUX_BASE  = 16'hF200,
  parameter int unsigned TXF_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataOutBus,
  input  logic        writeEnBus,
  output logic [7:0]  dataInBus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;
  localparam int unsigned CW        = $clog2(TXF_DEPTH) + 1;

  logic [7:0]        ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_addr;
  region_t           region;
  logic [15:0]       prev_addr;
  logic              status_edge;
  logic              rx_pop;
  logic [7:0]        rx_hold;
  logic              rx_full;
  logic              rx_overrun;
  logic              tx_overflow;
  logic              tx_not_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  always_comb begin
    ram_addr = addressBus[RAM_AW-1:0];
    region   = REGION_NONE;
    if (32'(addressBus) < RAM_WORDS)                  region = REGION_RAM;
    else if (addressBus == MUX_BASE + MUX_STATUS_OFS) region = REGION_STATUS;
    else if (addressBus == MUX_BASE + MUX_DATA_OFS)   region = REGION_DATA;

    // read side effects fire only when the address has just moved onto a register
    status_edge = (region == REGION_STATUS) && (addressBus != prev_addr);
    rx_pop      = (region == REGION_DATA) && (addressBus != prev_addr) && !writeEnBus;

    fifo_push   = (region == REGION_DATA) && writeEnBus;
    fifo_pop    = tx_valid && tx_ready;
    tx_valid    = ~fifo_empty;
    tx_not_full = (fifo_count < CW'(TXF_DEPTH));
  end

  sync_fifo #(
    .DEPTH (TXF_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (dataOutBus),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset && writeEnBus && region == REGION_RAM) ram[ram_addr] <= dataOutBus;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dataInBus   <= UNMAPPED_READ;
      prev_addr   <= '1;
      rx_hold     <= '0;
      rx_full     <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      prev_addr <= addressBus;
      unique case (region)
        REGION_RAM:    dataInBus <= ram[ram_addr];
        REGION_STATUS: dataInBus <= pack_status(rx_full, tx_not_full, rx_overrun, tx_overflow);
        REGION_DATA:   dataInBus <= rx_hold;
        default:       dataInBus <= UNMAPPED_READ;
      endcase

      if (status_edge) begin
        rx_overrun  <= 1'b0;
        tx_overflow <= 1'b0;
      end
      if (fifo_push && fifo_full && !fifo_pop) tx_overflow <= 1'b1;

      if (rx_valid) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
        if (rx_full && !rx_pop) rx_overrun <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_target.sv
// Scoreboard bench for bus_target: expected bytes are queued as stimulus is
// driven and compared as dataInBus / tx_data present them.
module tb_bus_target;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addressBus;
  logic [7:0]  dataOutBus;
  logic        writeEnBus;
  logic [7:0]  dataInBus;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  localparam logic [15:0] ST = 16'hF200;
  localparam logic [15:0] DT = 16'hF201;
  localparam logic [15:0] UN = 16'h9000;

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [7:0]  wd;
    logic        chk;
    logic [7:0]  exp;
    logic        rxv;
    logic [7:0]  rxd;
    logic        rdy;
  } step_t;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clock = ~clock;

  bus_target #(
    .RAM_AW    (15),
    .MUX_BASE  (16'hF200),
    .TXF_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .addressBus (addressBus),
    .dataOutBus (dataOutBus),
    .writeEnBus (writeEnBus),
    .dataInBus  (dataInBus),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid)
  );

  function automatic step_t mk(input logic [15:0] a, input logic we, input logic [7:0] wd,
                               input logic chk, input logic [7:0] exp,
                               input logic rxv = 1'b0, input logic [7:0] rxd = 8'h00,
                               input logic rdy = 1'b0);
    step_t s;
    s.a = a; s.we = we; s.wd = wd; s.chk = chk; s.exp = exp;
    s.rxv = rxv; s.rxd = rxd; s.rdy = rdy;
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input step_t s);
    addressBus = s.a;
    writeEnBus = s.we;
    dataOutBus = s.wd;
    rx_valid   = s.rxv;
    rx_data    = s.rxd;
    tx_ready   = s.rdy;
  endtask

  task automatic test_reset();
    sb_t e;
    reset = 1'b1;
    drive(mk(UN, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1));
    sb_q.push_back('{"reset_data", 8'hFF});
    tick();
    tick();
    e = sb_q.pop_front();
    n_checks++;
    if (dataInBus !== e.v) begin
      n_fail++;
      $display("FAIL %s: dataInBus=%h expected %h", e.nm, dataInBus, e.v);
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tx_valid: tx_valid=%b expected 0", tx_valid);
    end
    reset = 1'b0;
    drive(mk(UN, 1'b0, 8'h00, 1'b0, 8'h00));
  endtask

  task automatic test_decode();
    step_t s[$];
    sb_t   e;
    s = '{mk(16'h0000, 1, 8'h12, 0, 8'h00), mk(16'h1000, 1, 8'h99, 0, 8'h00),
          mk(16'h7FFF, 1, 8'h3C, 0, 8'h00), mk(16'h0123, 1, 8'h11, 0, 8'h00),
          mk(16'h0123, 1, 8'h5A, 1, 8'h11), mk(16'h0123, 0, 8'h00, 1, 8'h5A),
          mk(16'h0123, 0, 8'h00, 1, 8'h5A), mk(UN,         1, 8'hEE, 1, 8'hFF),
          mk(16'h8000, 1, 8'h77, 1, 8'hFF), mk(16'h1000, 0, 8'h00, 1, 8'h99),
          mk(16'h0000, 0, 8'h00, 1, 8'h12), mk(16'h7FFF, 0, 8'h00, 1, 8'h3C),
          mk(16'hF1FF, 0, 8'h00, 1, 8'hFF), mk(16'hF202, 0, 8'h00, 1, 8'hFF),
          mk(ST,         1, 8'hFF, 1, 8'h02), mk(ST,         0, 8'h00, 1, 8'h02)};
    foreach (s[i]) begin
      drive(s[i]);
      if (s[i].chk) sb_q.push_back('{$sformatf("decode[%0d]", i), s[i].exp});
      tick();
      if (s[i].chk) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dataInBus !== e.v) begin
          n_fail++;
          $display("FAIL %s: dataInBus=%h expected %h", e.nm, dataInBus, e.v);
        end
      end
    end
  endtask

  task automatic test_tx_overflow();
    step_t s[$];
    sb_t   e;
    s = '{mk(DT, 1, 8'h01, 0, 8'h00), mk(DT, 1, 8'h02, 0, 8'h00), mk(DT, 1, 8'h03, 0, 8'h00),
          mk(DT, 1, 8'h04, 0, 8'h00), mk(DT, 1, 8'h05, 0, 8'h00), mk(ST, 0, 8'h00, 1, 8'h08),
          mk(UN, 0, 8'h00, 1, 8'hFF), mk(ST, 0, 8'h00, 1, 8'h00)};
    foreach (s[i]) begin
      drive(s[i]);
      if (s[i].chk) sb_q.push_back('{$sformatf("tx_status[%0d]", i), s[i].exp});
      tick();
      if (s[i].chk) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dataInBus !== e.v) begin
          n_fail++;
          $display("FAIL %s: dataInBus=%h expected %h", e.nm, dataInBus, e.v);
        end
      end
    end
    for (int v = 1; v <= 4; v++) sb_q.push_back('{$sformatf("tx_drain[%0d]", v), 8'(v)});
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = sb_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e.v) begin
        n_fail++;
        $display("FAIL %s: tx_valid=%b tx_data=%h expected valid %h", e.nm, tx_valid, tx_data, e.v);
      end
      tick();
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_drained: tx_valid=%b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    step_t      s[$];
    sb_t        e;
    logic [7:0] tail[4];
    s = '{mk(DT, 1, 8'hB1, 0, 8'h00), mk(DT, 1, 8'hB2, 0, 8'h00), mk(DT, 1, 8'hB3, 0, 8'h00),
          mk(DT, 1, 8'hB4, 0, 8'h00), mk(DT, 1, 8'hAA, 0, 8'h00, 0, 8'h00, 1),
          mk(ST, 0, 8'h00, 1, 8'h00)};
    foreach (s[i]) begin
      drive(s[i]);
      if (s[i].chk) sb_q.push_back('{$sformatf("b2b_status[%0d]", i), s[i].exp});
      tick();
      if (s[i].chk) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dataInBus !== e.v) begin
          n_fail++;
          $display("FAIL %s: dataInBus=%h expected %h", e.nm, dataInBus, e.v);
        end
      end
    end
    tail = '{8'hB2, 8'hB3, 8'hB4, 8'hAA};
    foreach (tail[i]) sb_q.push_back('{$sformatf("b2b_drain[%0d]", i), tail[i]});
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = sb_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e.v) begin
        n_fail++;
        $display("FAIL %s: tx_valid=%b tx_data=%h expected valid %h", e.nm, tx_valid, tx_data, e.v);
      end
      tick();
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drained: tx_valid=%b expected 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_read();
    step_t s[$];
    sb_t   e;
    s = '{mk(UN, 0, 8'h00, 1, 8'hFF, 1, 8'h41), mk(DT, 0, 8'h00, 1, 8'h41),
          mk(DT, 0, 8'h00, 1, 8'h41, 1, 8'h42), mk(DT, 0, 8'h00, 1, 8'h42),
          mk(ST, 0, 8'h00, 1, 8'h03), mk(DT, 0, 8'h00, 1, 8'h42),
          mk(ST, 0, 8'h00, 1, 8'h02)};
    foreach (s[i]) begin
      drive(s[i]);
      if (s[i].chk) sb_q.push_back('{$sformatf("rx_read[%0d]", i), s[i].exp});
      tick();
      if (s[i].chk) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dataInBus !== e.v) begin
          n_fail++;
          $display("FAIL %s: dataInBus=%h expected %h", e.nm, dataInBus, e.v);
        end
      end
    end
  endtask

  task automatic test_rx_overrun();
    step_t s[$];
    sb_t   e;
    s = '{mk(UN, 0, 8'h00, 1, 8'hFF, 1, 8'h10), mk(UN, 0, 8'h00, 1, 8'hFF, 1, 8'h20),
          mk(ST, 0, 8'h00, 1, 8'h07), mk(DT, 0, 8'h00, 1, 8'h20),
          mk(UN, 0, 8'h00, 1, 8'hFF, 1, 8'h30), mk(DT, 0, 8'h00, 1, 8'h30, 1, 8'h40),
          mk(ST, 0, 8'h00, 1, 8'h03), mk(DT, 0, 8'h00, 1, 8'h40),
          mk(ST, 0, 8'h00, 1, 8'h02)};
    foreach (s[i]) begin
      drive(s[i]);
      if (s[i].chk) sb_q.push_back('{$sformatf("rx_overrun[%0d]", i), s[i].exp});
      tick();
      if (s[i].chk) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dataInBus !== e.v) begin
          n_fail++;
          $display("FAIL %s: dataInBus=%h expected %h", e.nm, dataInBus, e.v);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    step_t s[$];
    sb_t   e;
    s = '{mk(DT, 1, 8'h01, 0, 8'h00), mk(DT, 1, 8'h02, 0, 8'h00), mk(DT, 1, 8'h03, 0, 8'h00),
          mk(UN, 0, 8'h00, 1, 8'hFF, 1, 8'h55)};
    foreach (s[i]) begin
      drive(s[i]);
      if (s[i].chk) sb_q.push_back('{$sformatf("pre_reset[%0d]", i), s[i].exp});
      tick();
      if (s[i].chk) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dataInBus !== e.v) begin
          n_fail++;
          $display("FAIL %s: dataInBus=%h expected %h", e.nm, dataInBus, e.v);
        end
      end
    end
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      n_fail++;
      $display("FAIL pre_reset_tx: tx_valid=%b tx_data=%h expected valid 01", tx_valid, tx_data);
    end
    reset = 1'b1;
    drive(mk(DT, 1, 8'h04, 0, 8'h00, 1, 8'h66, 1));
    sb_q.push_back('{"mid_reset_data", 8'hFF});
    tick();
    e = sb_q.pop_front();
    n_checks++;
    if (dataInBus !== e.v || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: dataInBus=%h tx_valid=%b expected %h and 0", e.nm, dataInBus, tx_valid, e.v);
    end
    reset = 1'b0;
    drive(mk(ST, 0, 8'h00, 1, 8'h02));
    sb_q.push_back('{"post_reset_status", 8'h02});
    tick();
    e = sb_q.pop_front();
    n_checks++;
    if (dataInBus !== e.v || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: dataInBus=%h tx_valid=%b expected %h and 0", e.nm, dataInBus, tx_valid, e.v);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(mk(UN, 0, 8'h00, 0, 8'h00));
    test_reset();
    test_decode();
    test_tx_overflow();
    test_back_to_back();
    test_rx_read();
    test_rx_overrun();
    test_reset_midstream();
    drive(mk(UN, 0, 8'h00, 0, 8'h00));
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
